// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: drives imem requests, applies EX redirects, buffers redirects during stalled requests, traps misaligned targets.
// Optional redirect counter output enabled by defining PC_REDIRECT_CNT_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    input  logic        imem_req_ready,
    output logic        imem_req_valid,
    output logic [31:0] pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [31:0] redirect_count
`endif
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_d;
    logic [31:0]        pend_q, pend_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic               exit_q, exit_d;
    logic               exc_d;
    logic [31:0]        addr_d;

    logic               redirect_req;
    logic               redirect_acc;
    logic               transfer;
    logic               misaligned;
    logic [31:0]        sel_target;
    logic [31:0]        eff_target;

    assign imem_req_valid = (state_q != BOOT) && !stall;
    assign transfer       = imem_req_valid && imem_req_ready;
    assign redirect_req   = ex_valid && (is_jalr || is_jal || (is_branch && branch_taken));
    // Redirects are only taken in RUN and not while a previous flush window is open
    assign redirect_acc   = redirect_req && (state_q == RUN) && (fcnt_q == '0);
    assign sel_target     = is_jalr ? jalr_target : (is_jal ? jal_target : branch_target);
    assign misaligned     = (sel_target[1:0] != 2'b00);
    assign eff_target     = misaligned ? TRAP_VEC : sel_target;

    assign flush_id_ex    = redirect_acc || (fcnt_q != '0);
    assign flush_if_id    = flush_id_ex || (state_q == PEND) || exit_q;

    // Next-state, PC and trap bookkeeping
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        pend_d  = pend_q;
        fcnt_d  = (fcnt_q != '0) ? fcnt_q - CNT_W'(1) : '0;
        exit_d  = 1'b0;
        exc_d   = 1'b0;
        addr_d  = misalign_addr;

        if (redirect_acc) begin
            fcnt_d = CNT_W'(FLUSH_CYCLES - 1);
            if (misaligned) begin
                exc_d  = 1'b1;
                addr_d = sel_target;
            end
        end

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_acc) begin
                    if (imem_req_valid && !imem_req_ready) begin
                        pend_d  = eff_target;
                        state_d = PEND;
                    end else begin
                        pc_d = eff_target;
                    end
                end else if (transfer) begin
                    pc_d = pc + 32'd4;
                end
            end
            PEND: begin
                if (transfer) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                    exit_d  = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc            <= RESET_PC;
            pend_q        <= '0;
            fcnt_q        <= '0;
            exit_q        <= 1'b0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state_q       <= state_d;
            pc            <= pc_d;
            pend_q        <= pend_d;
            fcnt_q        <= fcnt_d;
            exit_q        <= exit_d;
            misalign_exc  <= exc_d;
            misalign_addr <= addr_d;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    // Saturating count of accepted redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_count <= '0;
        end else if (redirect_acc && (redirect_count != 32'hFFFF_FFFF)) begin
            redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed test-plan scenarios followed by random traffic against a reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst, stall, ex_valid, is_branch, is_jal, is_jalr, branch_taken;
    logic [31:0] branch_target, jal_target, jalr_target;
    logic        imem_req_ready;
    logic        imem_req_valid;
    logic [31:0] pc;
    logic        flush_if_id, flush_id_ex, misalign_exc;
    logic [31:0] misalign_addr;
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_count;
`endif

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC(RESET_PC),
        .TRAP_VEC(TRAP_VEC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .ex_valid(ex_valid),
        .is_branch(is_branch),
        .is_jal(is_jal),
        .is_jalr(is_jalr),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jal_target(jal_target),
        .jalr_target(jalr_target),
        .imem_req_ready(imem_req_ready),
        .imem_req_valid(imem_req_valid),
        .pc(pc),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr)
`ifdef PC_REDIRECT_CNT_EN
        ,
        .redirect_count(redirect_count)
`endif
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        fi;
        logic        fe;
        logic        exc;
        logic [31:0] addr;
        logic [31:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;

    // Reference model: abstract fetch behaviour
    bit          m_known = 0;
    bit          m_booting;
    bit          m_pending;
    logic [31:0] m_pend_target;
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_after_pend;
    bit          m_exc;
    logic [31:0] m_addr;
    longint      m_cnt;

    task automatic cyc(input bit r, input bit s, input bit ev, input bit br, input bit jl,
                       input bit jr, input bit tk, input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] rt, input bit rdy);
        bit          want, acc, v, xfer, mis;
        logic [31:0] tgt, eff;
        obs_t        e;
        @(negedge clk);
        rst = r; stall = s; ex_valid = ev; is_branch = br; is_jal = jl; is_jalr = jr;
        branch_taken = tk; branch_target = bt; jal_target = jt; jalr_target = rt;
        imem_req_ready = rdy;
        cyc_no++;
        if (m_known) begin
            want = ev && (jr || jl || (br && tk));
            acc  = want && !m_booting && !m_pending && (m_flush_left == 0);
            tgt  = jr ? rt : (jl ? jt : bt);
            mis  = (tgt % 4) != 0;
            eff  = mis ? TRAP_VEC : tgt;
            v    = !m_booting && !s;
            xfer = v && rdy;
            e.v   = v;
            e.pc  = m_pc;
            e.fe  = acc || (m_flush_left > 0);
            e.fi  = e.fe || m_pending || m_after_pend;
            e.exc = m_exc;
            e.addr = m_addr;
`ifdef PC_REDIRECT_CNT_EN
            e.cnt = 32'(m_cnt);
`else
            e.cnt = '0;
`endif
            exp_q.push_back(e);
            m_exc        = acc && mis;
            if (acc && mis) m_addr = tgt;
            m_flush_left = acc ? FLUSH_CYCLES - 1 : (m_flush_left > 0 ? m_flush_left - 1 : 0);
            m_after_pend = m_pending && xfer;
            if (acc && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_booting) begin
                m_booting = 0;
            end else if (m_pending) begin
                if (xfer) begin
                    m_pc = m_pend_target;
                    m_pending = 0;
                end
            end else if (acc) begin
                if (v && !rdy) begin
                    m_pending = 1;
                    m_pend_target = eff;
                end else begin
                    m_pc = eff;
                end
            end else if (xfer) begin
                m_pc = m_pc + 32'd4;
            end
        end
        if (r) begin
            m_known = 1; m_booting = 1; m_pending = 0; m_pend_target = '0;
            m_pc = RESET_PC; m_flush_left = 0; m_after_pend = 0;
            m_exc = 0; m_addr = '0; m_cnt = 0;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, rdy);
    endtask

    // Monitor: pops an expected observation every cycle one was issued
    always @(negedge clk) begin
        obs_t a, e;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.v = imem_req_valid; a.pc = pc; a.fi = flush_if_id; a.fe = flush_id_ex;
            a.exc = misalign_exc; a.addr = misalign_addr;
`ifdef PC_REDIRECT_CNT_EN
            a.cnt = redirect_count;
`else
            a.cnt = '0;
`endif
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL obs t=%0t: got v=%b pc=%h fi=%b fe=%b exc=%b addr=%h cnt=%h, want v=%b pc=%h fi=%b fe=%b exc=%b addr=%h cnt=%h",
                         $time, a.v, a.pc, a.fi, a.fe, a.exc, a.addr, a.cnt,
                         e.v, e.pc, e.fi, e.fe, e.exc, e.addr, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] t;
        rst = 1; stall = 0; ex_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        branch_taken = 0; branch_target = '0; jal_target = '0; jalr_target = '0;
        imem_req_ready = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 1);
        idle(5, 1);
        // JAL to 0x200
        cyc(0, 0, 1, 0, 1, 0, 0, '0, 32'h200, '0, 1);
        idle(4, 1);
        // JALR held behind an unready memory
        cyc(0, 0, 1, 0, 0, 1, 0, '0, '0, 32'h1000, 0);
        idle(2, 0);
        idle(4, 1);
        // misaligned taken branch
        cyc(0, 0, 1, 1, 0, 0, 1, 32'h102, '0, '0, 1);
        idle(3, 1);
        // not-taken branch, then jal+jalr together
        cyc(0, 0, 1, 1, 0, 0, 0, 32'h500, '0, '0, 1);
        idle(1, 1);
        cyc(0, 0, 1, 0, 1, 1, 0, '0, 32'h2000, 32'h3000, 1);
        idle(3, 1);
        // redirect under stall, then wrap past the top of memory
        cyc(0, 1, 1, 0, 1, 0, 0, '0, 32'hFFFF_FFF8, '0, 1);
        idle(4, 1);
        // reset while pending
        cyc(0, 0, 1, 0, 1, 0, 0, '0, 32'h40, '0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0);
        idle(4, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, ev, rdy;
            logic [31:0] bt, jt, rt;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 3) == 0);
            ev  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            bt  = $urandom; jt = $urandom; rt = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                bt[1:0] = 2'b00; jt[1:0] = 2'b00; rt[1:0] = 2'b00;
            end
            t = bt;
            cyc(r, s, ev, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom), t, jt, rt, rdy);
        end
        idle(2, 1);
        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d leftover expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the execute-stage target calculator.
- Owns the architectural fetch PC and drives instruction-memory requests with a valid/ready handshake.
- Accepts resolved branch, JAL and JALR targets from EX and redirects fetch to them.
- Generates pipeline flushes, buffers redirects that arrive while a fetch request is stalled, and traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap.
- FLUSH_CYCLES, 2, cycles flush_if_id/flush_id_ex stay high per redirect (legal range 1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard-unit freeze of the IF stage.
- ex_valid  in  1  EX stage holds a valid instruction.
- is_branch  in  1  EX instruction is a conditional branch.
- is_jal  in  1  EX instruction is JAL.
- is_jalr  in  1  EX instruction is JALR.
- branch_taken  in  1  branch condition result from ALU.
- branch_target  in  32  PC+imm for B-type.
- jal_target  in  32  PC+imm for J-type.
- jalr_target  in  32  (rs1+imm)&~1.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_req_valid  out  1  fetch request valid.
- pc  out  32  current fetch address (imem address).
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- misalign_exc  out  1  one-cycle trap pulse.
- misalign_addr  out  32  offending target, held until the next trap.

Behaviour:
- States: BOOT, RUN, PEND.
- Reset (rst=1, overrides all inputs): pc=RESET_PC, state=BOOT, imem_req_valid=0, flush_*=0, misalign_exc=0, misalign_addr=0, flush counter=0, pend_pc=0.
- BOOT: one cycle with imem_req_valid=0, then RUN.
- imem_req_valid = (state==RUN or PEND) & !stall. Combinational from state and stall.
- Handshake rules:
  - Transfer = imem_req_valid & imem_req_ready.
  - pc must stay stable while imem_req_valid=1 and imem_req_ready=0.
- redirect = ex_valid & (is_jalr | is_jal | (is_branch & branch_taken)), ignored while the flush counter is nonzero.
- Target priority is jalr > jal > branch. If more than one flag is set, the highest-priority target is used.
- Misalignment: sel_target[1:0] != 2'b00. The effective target becomes TRAP_VEC. Next cycle misalign_exc=1 for exactly one cycle and misalign_addr=sel_target.
- RUN:
  - redirect and (no pending handshake, i.e. !imem_req_valid or imem_req_ready): pc<=effective target next cycle, stay RUN.
  - redirect while imem_req_valid & !imem_req_ready: pend_pc<=effective target, go to PEND, pc unchanged.
  - no redirect, transfer: pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - no redirect, no transfer: hold pc.
- PEND:
  - pc held. When the transfer completes, pc<=pend_pc and go to RUN.
  - Further redirects are ignored.
  - flush_if_id is forced high throughout PEND and for the cycle following exit, so the wrong-path fetch is squashed.
- Flush:
  - On an accepted redirect, flush_if_id and flush_id_ex go high in the same cycle (combinational).
  - They stay high for FLUSH_CYCLES total cycles via a down-counter loaded with FLUSH_CYCLES-1.
  - stall does not pause the counter.
- Redirect has priority over stall: pc updates even if stall=1, unless a request is pending un-acked.
- Reset mid-PEND: pending target discarded, BOOT re-entered.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- Defined: adds output port redirect_count (32 bits, out).
  - Increments on every accepted redirect, including trap redirects.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset release, imem_req_ready=1, no redirects:
  - cycle after BOOT: imem_req_valid=1, pc=0x0.
  - pc then reads 0x4, 0x8, 0xC on consecutive cycles.
- JAL to 0x200 with ex_valid=1, ready=1:
  - flush_if_id/flush_id_ex high for exactly 2 cycles.
  - next-cycle pc=0x200, then 0x204.
- JALR with jalr_target=0x1000, imem_req_ready=0 for 3 cycles:
  - pc holds its old value, state PEND, flush_if_id high.
  - on the ready cycle the transfer completes; next pc=0x1000.
- Branch taken, branch_target=0x102:
  - next pc=0x100 (TRAP_VEC), misalign_exc high one cycle, misalign_addr=0x102.
- Branch with branch_taken=0, and flags is_jal=is_jalr=1 with distinct targets:
  - the first causes no redirect (pc+4 continues).
  - the second selects jalr_target.
- pc=0xFFFF_FFFC with a transfer:
  - pc wraps to 0x0.
- rst asserted in PEND:
  - pc=RESET_PC and imem_req_valid=0 on the next cycle.
  - with PC_REDIRECT_CNT_EN, redirect_count=0.
